// File: rtl/serial_adder_st_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings and counter sizing.
package serial_adder_st_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter only needs to reach WIDTH-1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_st_full_adder.sv
// One-bit structural full adder (gate primitives), used as the serial bit cell.
module full_adder_st (
  input  wire x,
  input  wire y,
  input  wire c,
  output wire s,
  output wire co
);

  wire w_p;
  wire w_g;
  wire w_t;

  xor u_xor_p (w_p, x, y);
  xor u_xor_s (s, w_p, c);
  and u_and_g (w_g, x, y);
  and u_and_t (w_t, c, w_p);
  or  u_or_co (co, w_g, w_t);

endmodule

// File: rtl/serial_adder_st.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
//
// state   | meaning
// IDLE    | waiting for start; result registers hold
// RUN     | one operand bit summed per edge, WIDTH edges
// DONE    | one-cycle done pulse, then back to IDLE
module serial_adder_st
  import serial_adder_st_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  full_adder_st u_fa (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .c  (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers are written only at the last RUN edge so no partial sum is ever visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_cnt   <= '0;
            r_carry <= 1'b0;
          end
        end
        ST_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_co;
          r_cnt    <= r_cnt + 1'b1;
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          if (w_last) begin
            r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
            r_cout <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // At the last step r_carry is the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_ovf <= 1'b0;
    else if (r_state == ST_RUN && w_last) r_ovf <= r_carry ^ w_co;
  end

  assign overflow = r_ovf;
`endif

  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule
